// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder sequencer.
// Adds two WIDTH-bit operands one bit per clock, LSB first, through a single
// 1-bit full adder (two half-add stages plus an OR of their carries).
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request, honoured only while idle
//   A, B  - operands, captured on an accepted start
//   Cin   - carry-in, captured on an accepted start
//   busy  - high while an addition is running or completing
//   done  - one-cycle completion pulse; Sum/Cout valid from this cycle on
//   Sum   - registered sum, held until the next completion
//   Cout  - registered carry-out, held until the next completion
module serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic             carry;
  logic             last;

  // Shared 1-bit full adder datapath
  logic a_k, b_k;
  logic h1_s, h1_c;
  logic h2_s, h2_c;
  logic fa_s, fa_c;

  assign a_k  = a_reg[0];
  assign b_k  = b_reg[0];
  assign h1_s = a_k ^ b_k;
  assign h1_c = a_k & b_k;
  assign h2_s = h1_s ^ carry;
  assign h2_c = h1_s & carry;
  assign fa_s = h2_s;
  assign fa_c = h1_c | h2_c;

  assign last = (cnt == CW'(WIDTH - 1));

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  always_comb begin
    sr_nxt            = sr >> 1;
    sr_nxt[WIDTH-1]   = fa_s;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      sr    <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            carry <= Cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          carry <= fa_c;
          sr    <= sr_nxt;
          if (last) begin
            cnt  <= '0;
            Sum  <= sr_nxt;
            Cout <= fa_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq at WIDTH=8, 4 and 1.
module tb_serial_add_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int errors = 0;
  int checks = 0;

  logic [8:0] sb8[$];
  logic [4:0] sb4[$];
  logic [1:0] sb1[$];

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
  );

  serial_add_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
    .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4)
  );

  serial_add_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on the 8-bit DUT, records the expected result and
  // waits (bounded) for done. lat = edges after acceptance until done seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output int lat, output int bcnt, output logic got);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    sb8.push_back(9'(a) + 9'(b) + 9'(c));
    tick();
    start8 = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      tick();
      lat++;
    end
    got = done8;
    if (busy8) bcnt++;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'b0) begin
      errors++;
      $display("FAIL reset_async8: busy=%b done=%b sum=%h cout=%b, required all 0", busy8, done8, sum8, cout8);
    end
    checks++;
    if ({busy4, done4, sum4, cout4, busy1, done1, sum1, cout1} !== 11'b0) begin
      errors++;
      $display("FAIL reset_async4_1: w4 %b%b%h%b w1 %b%b%b%b, required all 0",
               busy4, done4, sum4, cout4, busy1, done1, sum1, cout1);
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({busy8, done8, sum8, cout8} !== 11'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: busy=%b done=%b sum=%h cout=%b, required all 0",
                 i, busy8, done8, sum8, cout8);
      end
    end
  endtask

  task automatic test_basic_add();
    int lat, bcnt;
    logic got;
    logic [8:0] exp;
    run8(8'h35, 8'h4A, 1'b0, lat, bcnt, got);
    exp = sb8.pop_front();
    checks++;
    if (!got || lat != 8) begin
      errors++;
      $display("FAIL basic_latency: done=%b after %0d edges, required done after 8", got, lat);
    end
    checks++;
    if (sum8 !== exp[7:0] || cout8 !== exp[8]) begin
      errors++;
      $display("FAIL basic_result: got %b/%h, required %b/%h", cout8, sum8, exp[8], exp[7:0]);
    end
    checks++;
    if (bcnt != 9) begin
      errors++;
      $display("FAIL basic_busy_len: got %0d cycles, required 9", bcnt);
    end
    tick();
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_done: done=%b busy=%b, required 0 0", done8, busy8);
    end
  endtask

  task automatic test_wrap();
    int lat, bcnt;
    logic got;
    logic [8:0] exp;
    logic [7:0] av[2] = '{8'hFF, 8'hFF};
    logic [7:0] bv[2] = '{8'h00, 8'hFF};
    for (int i = 0; i < 2; i++) begin
      run8(av[i], bv[i], 1'b1, lat, bcnt, got);
      exp = sb8.pop_front();
      checks++;
      if (!got || sum8 !== exp[7:0] || cout8 !== exp[8]) begin
        errors++;
        $display("FAIL wrap_%0d: done=%b got %b/%h, required %b/%h", i, got, cout8, sum8, exp[8], exp[7:0]);
      end
      tick();
    end
  endtask

  task automatic test_busy_protect();
    logic [8:0] exp;
    int dones = 0;
    logic [7:0] gs = '0;
    logic gc = 1'b0;
    a8 = 8'h10; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    sb8.push_back(9'(8'h10) + 9'(8'h01));
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a8 = ~a8;
      b8 = ~b8;
      tick();
      if (done8) begin
        dones++;
        gs = sum8;
        gc = cout8;
      end
    end
    exp = sb8.pop_front();
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL busy_single_done: got %0d done pulses, required 1", dones);
    end
    checks++;
    if (gs !== exp[7:0] || gc !== exp[8] || sum8 !== exp[7:0]) begin
      errors++;
      $display("FAIL busy_result: got %b/%h (now %h), required %b/%h", gc, gs, sum8, exp[8], exp[7:0]);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_second: busy=%b, required 0", busy8);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, dones;
    logic got;
    logic [8:0] exp;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b, required all 0", busy8, done8, sum8, cout8);
    end
    #2;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) dones++;
    end
    checks++;
    if (dones != 0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: dones=%0d sum=%h cout=%b, required 0 00 0", dones, sum8, cout8);
    end
    run8(8'h80, 8'h80, 1'b0, lat, bcnt, got);
    exp = sb8.pop_front();
    checks++;
    if (!got || sum8 !== exp[7:0] || cout8 !== exp[8]) begin
      errors++;
      $display("FAIL reset_mid_fresh: done=%b got %b/%h, required %b/%h", got, cout8, sum8, exp[8], exp[7:0]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic prev;
    int accepts = 0, dones = 0, last_acc = -1, t = 0;
    logic [8:0] exp;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'b1;
    prev = busy8;
    while (dones < 6 && t < 120) begin
      tick();
      t++;
      if (!prev && busy8) begin
        accepts++;
        if (last_acc >= 0) begin
          checks++;
          if (t - last_acc != 10) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles between accepts, required 10", t - last_acc);
          end
        end
        last_acc = t;
        sb8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
        if (accepts == 6) start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      if (done8) begin
        dones++;
        checks++;
        if (sb8.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_done: got done with empty scoreboard, required none");
        end else begin
          exp = sb8.pop_front();
          if (sum8 !== exp[7:0] || cout8 !== exp[8]) begin
            errors++;
            $display("FAIL b2b_result %0d: got %b/%h, required %b/%h", dones, cout8, sum8, exp[8], exp[7:0]);
          end
        end
      end
      prev = busy8;
    end
    start8 = 1'b0;
    checks++;
    if (dones != 6 || sb8.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d dones, %0d pending, required 6 and 0", dones, sb8.size());
    end
    tick();
    tick();
  endtask

  task automatic test_exhaustive_w4();
    int e;
    logic [4:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
          sb4.push_back(5'(a) + 5'(b) + 5'(c));
          tick();
          start4 = 1'b0;
          e = 0;
          while (!done4 && e < 20) begin
            tick();
            e++;
          end
          exp = sb4.pop_front();
          checks++;
          if (!done4 || {cout4, sum4} !== exp || e != 4) begin
            errors++;
            $display("FAIL w4 %0d+%0d+%0d: done=%b lat=%0d got %b/%h, required lat 4 %b/%h",
                     a, b, c, done4, e, cout4, sum4, exp[4], exp[3:0]);
          end
          tick();
        end
      end
    end
  endtask

  task automatic test_exhaustive_w1();
    int e, bcnt;
    logic [1:0] exp;
    for (int v = 0; v < 8; v++) begin
      a1 = 1'(v); b1 = 1'(v >> 1); cin1 = 1'(v >> 2); start1 = 1'b1;
      sb1.push_back(2'(v & 1) + 2'((v >> 1) & 1) + 2'((v >> 2) & 1));
      tick();
      start1 = 1'b0;
      e = 0;
      bcnt = 0;
      while (!done1 && e < 20) begin
        if (busy1) bcnt++;
        tick();
        e++;
      end
      if (busy1) bcnt++;
      exp = sb1.pop_front();
      checks++;
      if (!done1 || {cout1, sum1} !== exp || e != 1 || bcnt != 2) begin
        errors++;
        $display("FAIL w1 case %0d: done=%b lat=%0d busy=%0d got %b/%b, required lat 1 busy 2 %b/%b",
                 v, done1, e, bcnt, cout1, sum1, exp[1], exp[0]);
      end
      tick();
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1_idle case %0d: busy=%b done=%b, required 0 0", v, busy1, done1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_wrap();
    test_busy_protect();
    test_reset_mid();
    test_back_to_back();
    test_exhaustive_w4();
    test_exhaustive_w1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
